// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares one data-memory port between the core (requester 0, "cpu") and the
// ML accelerator load/store engine (requester 1, "acc"). The memory reads
// asynchronously and writes on the rising clock edge, so a granted access
// completes in the cycle it is granted.
//
// Policy: the CPU has fixed priority. A starvation counter forces one ACC win
// after MAX_STARVE consecutive ungranted ACC request cycles. ACC may hold
// acc_lock to keep the port for a burst of at most MAX_BURST beats.
//
// Handshake: req is a per-cycle request; gnt means the access was performed
// in that same cycle. A stalled requester keeps req and its payload stable
// until it sees gnt. It may also drop req without being served.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata    CPU request and payload
//   cpu_gnt, cpu_stall       CPU grant; stall = req & ~gnt (PC hold)
//   cpu_rdata                mem_rd when cpu_gnt, else 0
//   acc_req/we/lock/addr/wdata  ACC request, payload and burst lock
//   acc_gnt, acc_rdata       ACC grant; mem_rd when acc_gnt, else 0
//   mem_we/addr/wd, mem_rd   data-memory port
//   dbg_state                owner FSM state (0 = ARB, 1 = BURST)
//   dbg_starve_cnt           starvation counter
//   dbg_burst_cnt            beats already taken in the current burst
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              acc_req,
    input  logic              acc_we,
    input  logic              acc_lock,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic [DATA_W-1:0] acc_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,

    output logic              dbg_state,
    output logic [7:0]        dbg_starve_cnt,
    output logic [7:0]        dbg_burst_cnt
);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [7:0] STARVE_LIM = 8'(MAX_STARVE);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    // A one-beat burst is just an ordinary ARB grant, so BURST is never entered.
    localparam bit         BURST_EN   = (MAX_BURST > 1);

    state_t     state;
    logic [7:0] starve_cnt;
    logic [7:0] burst_cnt;

    logic acc_wins_arb;
    logic cpu_gnt_c;
    logic acc_gnt_c;

    // Grants are decoded from the registered state. They are forced low
    // while rst is asserted so that no write can leak through during reset.
    always_comb begin
        acc_wins_arb = acc_req & ((starve_cnt == STARVE_LIM) | ~cpu_req);
        cpu_gnt_c    = 1'b0;
        acc_gnt_c    = 1'b0;
        if (rst) begin
            if (state == ARB) begin
                if (acc_wins_arb) begin
                    acc_gnt_c = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt_c = 1'b1;
                end
            end else begin
                acc_gnt_c = acc_req;
            end
        end
    end

    // Memory mux: only the granted requester reaches the memory. With no
    // grant the port is driven to all zeros.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (cpu_gnt_c) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wdata;
        end else if (acc_gnt_c) begin
            mem_we   = acc_we;
            mem_addr = acc_addr;
            mem_wd   = acc_wdata;
        end
    end

    assign cpu_gnt   = cpu_gnt_c;
    assign acc_gnt   = acc_gnt_c;
    assign cpu_stall = cpu_req & ~cpu_gnt_c;
    assign cpu_rdata = cpu_gnt_c ? mem_rd : '0;
    assign acc_rdata = acc_gnt_c ? mem_rd : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB;
            starve_cnt <= 8'd0;
            burst_cnt  <= 8'd0;
        end else begin
            // The starvation counter tracks consecutive unserved ACC
            // request cycles only.
            if (acc_gnt_c) begin
                starve_cnt <= 8'd0;
            end else if (acc_req) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 8'd1;
                end
            end else begin
                starve_cnt <= 8'd0;
            end

            case (state)
                ARB: begin
                    if (acc_gnt_c && acc_lock && BURST_EN) begin
                        state     <= BURST;
                        burst_cnt <= 8'd1;
                    end
                end
                BURST: begin
                    // burst_cnt holds the beats already taken, so the current
                    // beat is number burst_cnt+1. The beat that drops the lock,
                    // or the final allowed beat, is still granted. After it the
                    // FSM returns to ARB, where starve_cnt is 0 and a waiting
                    // CPU wins.
                    if (!acc_req || !acc_lock || (burst_cnt == BURST_LAST)) begin
                        state     <= ARB;
                        burst_cnt <= 8'd0;
                    end else begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= ARB;
                    burst_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign dbg_state      = (state == BURST);
    assign dbg_starve_cnt = starve_cnt;
    assign dbg_burst_cnt  = burst_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter (MAX_STARVE=4, MAX_BURST=8).
// It models a 256-word data memory, applies a table of single-cycle vectors,
// and then runs hand-written burst, early-unlock and reset-mid-burst sequences.
// The burst writes are tracked in an expected-data queue and read back.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              acc_req = 1'b0, acc_we = 1'b0, acc_lock = 1'b0;
    logic [ADDR_W-1:0] acc_addr = '0;
    logic [DATA_W-1:0] acc_wdata = '0;
    logic              acc_gnt;
    logic [DATA_W-1:0] acc_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;
    logic              dbg_state;
    logic [7:0]        dbg_starve_cnt, dbg_burst_cnt;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(4), .MAX_BURST(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .acc_req(acc_req), .acc_we(acc_we), .acc_lock(acc_lock), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rdata(acc_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt), .dbg_burst_cnt(dbg_burst_cnt)
    );

    // ---------------- data memory model ----------------
    logic [DATA_W-1:0] mem [0:255] = '{default: '0};
    assign mem_rd = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wd;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string             name;
        logic              rst, creq, cwe;
        logic [ADDR_W-1:0] caddr;
        logic [DATA_W-1:0] cwd;
        logic              areq, awe, alock;
        logic [ADDR_W-1:0] aaddr;
        logic [DATA_W-1:0] awd;
        logic              ecg, eag;   // expected grants
        logic [DATA_W-1:0] erd;        // expected read data on the granted side
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic creq, input logic cwe,
                       input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic areq, input logic awe, input logic alock,
                       input logic [31:0] aaddr, input logic [31:0] awd,
                       input logic ecg, input logic eag, input logic [31:0] erd);
        vec_t v;
        v.name = name; v.rst = r; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.areq = areq; v.awe = awe; v.alock = alock; v.aaddr = aaddr; v.awd = awd;
        v.ecg = ecg; v.eag = eag; v.erd = erd;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic areq, input logic awe,
                         input logic alock, input logic [31:0] aaddr, input logic [31:0] awd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        acc_req = areq; acc_we = awe; acc_lock = alock; acc_addr = aaddr; acc_wdata = awd;
    endtask

    task automatic apply_vec(input vec_t v);
        logic              ewe;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] ewd;
        rst = v.rst;
        drive(v.creq, v.cwe, v.caddr, v.cwd, v.areq, v.awe, v.alock, v.aaddr, v.awd);
        ewe   = v.ecg ? v.cwe   : (v.eag ? v.awe   : 1'b0);
        eaddr = v.ecg ? v.caddr : (v.eag ? v.aaddr : '0);
        ewd   = v.ecg ? v.cwd   : (v.eag ? v.awd   : '0);
        @(negedge clk);
        check({v.name, ".cpu_gnt"},   32'(cpu_gnt),   32'(v.ecg));
        check({v.name, ".acc_gnt"},   32'(acc_gnt),   32'(v.eag));
        check({v.name, ".cpu_stall"}, 32'(cpu_stall), 32'(v.creq & ~v.ecg));
        check({v.name, ".mem_we"},    32'(mem_we),    32'(ewe));
        check({v.name, ".mem_addr"},  mem_addr,       eaddr);
        check({v.name, ".mem_wd"},    mem_wd,         ewd);
        check({v.name, ".cpu_rdata"}, cpu_rdata,      v.ecg ? v.erd : 32'h0);
        check({v.name, ".acc_rdata"}, acc_rdata,      v.eag ? v.erd : 32'h0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] bdata;
        int                beat;
        int                nacc;

        // reset held with both requesting and CPU writing: nothing may reach memory
        for (int i = 0; i < 3; i++)
            add("rst_hold", 0, 1, 1, 32'h20, 32'h1111, 1, 1, 0, 32'h24, 32'h2222, 0, 0, 0);
        // first cycle after release: starve_cnt=0, CPU wins the simultaneous request
        add("rst_rel",  1, 1, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0, 1, 0, 32'h0);
        // CPU only: write, then read back
        add("cpu_wr",   1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        add("cpu_rd",   1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        add("idle",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("acc_rd",   1, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0, 0, 1, 32'hDEADBEEF);
        // starvation: both requesting continuously -> C,C,C,C,A repeating
        for (int i = 0; i < 10; i++)
            add("starve", 1, 1, 0, 32'h10, 0, 1, 0, 0, 32'h10, 0,
                (i % 5) != 4, (i % 5) == 4, 32'hDEADBEEF);
        add("idle2",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

        // ---- locked burst: acc_req=acc_lock=1 for 12 cycles, CPU waiting ----
        beat  = 0;
        bdata = $urandom;
        for (int i = 0; i < 12; i++) begin
            drive(i > 0, 0, 32'h10, 0, 1, 1, 1, 32'h40 + 32'(beat), bdata);
            @(negedge clk);
            check("burst.acc_gnt", 32'(acc_gnt), 32'(i < 8));
            check("burst.cpu_gnt", 32'(cpu_gnt), 32'(i >= 8));
            if (i < 8) begin
                exp_q.push_back(bdata);
                beat++;
                bdata = $urandom;
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        // read back the 8 burst addresses
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 32'h40 + 32'(k), 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("rdback.cpu_gnt", 32'(cpu_gnt), 32'h1);
            if (exp_q.size() > 0) check("rdback.data", cpu_rdata, exp_q.pop_front());
            @(posedge clk); #1;
        end
        check("sb.empty", 32'(exp_q.size()), 32'h0);

        // ---- early unlock: lock dropped on beat 3 ----
        nacc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(i > 0, 0, 32'h10, 0, 1, 0, i < 2, 32'h10, 0);
            @(negedge clk);
            if (acc_gnt) nacc++;
            if (i == 3) begin
                check("unlock.cpu_gnt",    32'(cpu_gnt), 32'h1);
                check("unlock.state",      32'(dbg_state), 32'h0);
                check("unlock.burst_cnt",  32'(dbg_burst_cnt), 32'h0);
                check("unlock.starve_cnt", 32'(dbg_starve_cnt), 32'h0);
            end
            @(posedge clk); #1;
        end
        check("unlock.acc_beats", 32'(nacc), 32'h3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // ---- reset mid-burst: rst asserted during beat 4 ----
        for (int i = 0; i < 4; i++) begin
            drive(i > 0, 0, 32'h10, 0, 1, 1, 1, 32'h80 + 32'(i), 32'hA000 + 32'(i));
            @(negedge clk);
            check("rstb.acc_gnt", 32'(acc_gnt), 32'h1);
            if (i == 3) begin
                #1 rst = 1'b0;
                #1;
                check("rstb.acc_gnt_now", 32'(acc_gnt), 32'h0);
                check("rstb.mem_we_now",  32'(mem_we), 32'h0);
                check("rstb.state_now",   32'(dbg_state), 32'h0);
                check("rstb.burst_now",   32'(dbg_burst_cnt), 32'h0);
            end
            @(posedge clk); #1;
        end
        check("rstb.mem_kept", mem[8'h83], 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rstb.rel_cpu_gnt", 32'(cpu_gnt), 32'h1);
        check("rstb.rel_acc_gnt", 32'(acc_gnt), 32'h0);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the single-cycle core (requester 0, CPU) and the ML accelerator's load/store engine (requester 1, ACC).
- Sits between both requesters and the data memory. The memory has an asynchronous read and a write on the clock edge.
- Policy: the CPU has fixed priority, with a starvation guard for ACC. ACC may lock the port for bounded bursts.
- Grants are combinational from the registered state, so a granted access completes in the same cycle. Sequential behaviour is the owner FSM plus the starvation and burst counters.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_STARVE, 4, number of consecutive cycles ACC may request without a grant before it is forced to win. Legal range 1..255.
- MAX_BURST, 8, maximum beats in one locked ACC burst. Legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request for the current cycle.
- cpu_we  in  1  CPU write (1) or read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_stall  out  1  equals cpu_req & ~cpu_gnt; drives the core's PC hold.
- cpu_rdata  out  DATA_W  equals mem_rd when cpu_gnt, else 0.
- acc_req  in  1  ACC access request.
- acc_we  in  1  ACC write (1) or read (0).
- acc_lock  in  1  ACC requests to keep ownership of the port for the next beat.
- acc_addr  in  ADDR_W  ACC address.
- acc_wdata  in  DATA_W  ACC write data.
- acc_gnt  out  1  ACC access performed this cycle.
- acc_rdata  out  DATA_W  equals mem_rd when acc_gnt, else 0.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wd  out  DATA_W  data-memory write data.
- mem_rd  in  DATA_W  data-memory read data (asynchronous).

Behaviour:
- State registers:
  - state: ARB or BURST.
  - starve_cnt: 8 bits.
  - burst_cnt: 8 bits.
- Reset:
  - While rst=0, state=ARB and both counters are 0.
  - While rst=0, cpu_gnt=acc_gnt=0, mem_we=0, mem_addr=0, mem_wd=0.
  - Reset asserted mid-burst aborts the burst immediately. The first cycle after release is ARB.
- Grant logic in ARB:
  - If acc_req & (starve_cnt==MAX_STARVE | ~cpu_req), ACC is granted.
  - Otherwise, if cpu_req, CPU is granted.
  - Otherwise, no grant.
- Grant logic in BURST:
  - acc_gnt = acc_req; cpu_gnt = 0.
- At most one grant is asserted per cycle.
- Memory mux:
  - The granted requester's addr and wdata drive mem_addr and mem_wd.
  - mem_we = that requester's we.
  - With no grant, mem_we=0 and addr/wd=0.
  - A write commits on the clock edge of the granted cycle. A read returns mem_rd in the same cycle (zero latency).
- starve_cnt:
  - Cleared on any cycle with acc_gnt.
  - Incremented (saturating at MAX_STARVE) when acc_req & ~acc_gnt.
  - Cleared when ~acc_req.
- Transitions from ARB:
  - If acc_gnt & acc_lock & MAX_BURST>1, go to BURST with burst_cnt=1.
  - Otherwise stay in ARB.
- Transitions from BURST:
  - If acc_gnt, burst_cnt increments.
  - Return to ARB (burst_cnt cleared) when ~acc_req, or ~acc_lock on the current beat, or burst_cnt==MAX_BURST-1 on a granted beat.
  - The beat carrying acc_lock=0, or the MAX_BURST-th beat, is still granted.
  - A total of MAX_BURST beats is never exceeded.
- After a burst ends, ARB priority rules apply with starve_cnt=0, so a waiting CPU wins the next cycle.
- Simultaneous requests with starve_cnt<MAX_STARVE: CPU wins.
- Simultaneous requests with starve_cnt==MAX_STARVE: ACC wins for exactly one beat (or a burst, if lock is set); the CPU stalls that cycle.
- Requester inputs are sampled only in the granted cycle. A stalled requester holds its request stable until granted. Dropping a request unserviced is legal and has no side effects.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with cpu_req=acc_req=1 and cpu_we=1 -> both gnts=0, mem_we=0; after release, the first cycle grants the CPU (starve_cnt=0).
- CPU only: CPU writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> cpu_gnt=1 both cycles, cpu_stall=0, cpu_rdata=0xDEADBEEF in the read cycle, acc_rdata=0.
- Starvation, MAX_STARVE=4: cpu_req and acc_req continuously high, no lock -> grant pattern repeats CPU,CPU,CPU,CPU,ACC; cpu_stall=1 only on the ACC cycle.
- Burst, MAX_BURST=8: ACC holds acc_req=acc_lock=1 for 12 cycles with cpu_req=1 -> acc_gnt for exactly 8 cycles, then cpu_gnt on cycle 9; ACC writes to 8 consecutive addresses land in memory.
- Early unlock: ACC burst with acc_lock dropped on beat 3 while cpu_req=1 -> 3 ACC beats, CPU granted on the next cycle; burst_cnt and starve_cnt return to 0.
- Reset mid-burst: assert rst=0 during beat 4 -> acc_gnt=0 immediately; after release, state is ARB and the CPU wins a simultaneous request.
